return_address_stack: RTL

RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

---
 rtl/riscv_defines.sv | 15 +
 rtl/return_address_stack.sv | 102 ++++++++++
 2 files changed

// File: rtl/riscv_defines.sv
// Shared front-end definitions: return address stack sizing and the
// checkpoint snapshot carried down the pipeline for misprediction recovery.
package riscv_defines;

  localparam int RAS_DEPTH_DEFAULT = 8;
  localparam int RAS_PTR_WIDTH     = $clog2(RAS_DEPTH_DEFAULT);
  localparam int RAS_CNT_WIDTH     = RAS_PTR_WIDTH + 1;

  typedef struct packed {
    logic [RAS_PTR_WIDTH-1:0] tos;
    logic [RAS_CNT_WIDTH-1:0] count;
    logic [31:0]              top;
  } ras_checkpoint_t;

endpackage

// File: rtl/return_address_stack.sv
// Circular return address stack for fetch-stage call/return prediction.
// RAS_RECOVERY_EN: restore from a checkpoint on flush; otherwise a flush empties the stack.
module return_address_stack
  import riscv_defines::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            push_en,
  input  logic [31:0]     push_addr,
  input  logic            pop_en,
  output logic            ras_empty,
  output logic [31:0]     ras_pop_addr,
  output ras_checkpoint_t cp_out,
  input  logic            restore_en,
  input  ras_checkpoint_t restore_cp
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [31:0]   r_stack [RAS_DEPTH];
  logic [PW-1:0] r_tos;
  logic [CW-1:0] r_cnt;

  logic [PW-1:0] w_tos_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  assign ras_pop_addr = r_stack[r_tos];
  assign ras_empty    = (r_cnt == '0);

  always_comb begin
    cp_out       = '0;
    cp_out.tos   = RAS_PTR_WIDTH'(r_tos);
    cp_out.count = RAS_CNT_WIDTH'(r_cnt);
    cp_out.top   = r_stack[r_tos];
  end

  // Single write port: every path below selects at most one stack write.
  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_tos;
    w_wdata   = push_addr;
    if (reset) begin
      w_tos_nxt = '0;
      w_cnt_nxt = '0;
    end else if (restore_en) begin
`ifdef RAS_RECOVERY_EN
      w_tos_nxt = PW'(restore_cp.tos);
      w_cnt_nxt = CW'(restore_cp.count);
      w_we      = 1'b1;
      w_waddr   = PW'(restore_cp.tos);
      w_wdata   = restore_cp.top;
`else
      w_tos_nxt = '0;
      w_cnt_nxt = '0;
`endif
    end else if (!stall_f) begin
      if (push_en && pop_en) begin
        // Return followed by call: replace the top in place.
        w_we = 1'b1;
      end else if (push_en) begin
        w_tos_nxt = r_tos + 1'b1;
        w_cnt_nxt = (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
        w_we      = 1'b1;
        w_waddr   = r_tos + 1'b1;
      end else if (pop_en && (r_cnt != '0)) begin
        w_tos_nxt = r_tos - 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

`ifndef RAS_RECOVERY_EN
  logic w_unused_cp;
  assign w_unused_cp = ^restore_cp;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tos <= '0;
      r_cnt <= '0;
    end else begin
      r_tos <= w_tos_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Contents are deliberately not reset; count gates their validity.
  always_ff @(posedge clk) begin
    if (w_we) r_stack[w_waddr] <= w_wdata;
  end

endmodule
